muldiv_seq: RTL and testbench

Iterative sequencer that executes the RV32M unsigned subset (MUL, MULHU, DIVU, REMU) by driving one shared 32-bit ALU instance over 32 add/subtract steps. It sits beside the integer ALU in the execute stage. It accepts one operation at a time over a valid/ready request channel and returns the 32-bit result over a valid/ready response channel. Handshakes let the pipeline stall on it.

---
 rtl/riscv_pkg.sv | 32 +++
 rtl/alu.sv | 29 ++
 rtl/muldiv_seq.sv | 159 +++++++++++++++
 tb/tb_muldiv_seq.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the execute-stage units.
// Holds the M-extension op codes, ALU controls and controller states.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    MD_MUL   = 2'b00,
    MD_MULHU = 2'b01,
    MD_DIVU  = 2'b10,
    MD_REMU  = 2'b11
  } md_op_e;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_RUN  = 2'b01,
    MD_DONE = 2'b10
  } md_state_e;

  function automatic logic md_is_div(
    input md_op_e op
  );
    return op[1];
  endfunction

endpackage

// File: rtl/alu.sv
// Integer ALU shared by the execute stage.
// Purely combinational; zero flags an all-zero result.
module alu
  import riscv_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   ctrl,
  output logic [W-1:0] result,
  output logic         zero
);

  always_comb begin
    result = '0;
    unique case (ctrl)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M unsigned mul/div unit.
// One shared ALU step per cycle: shift-add multiply, restoring divide.
module muldiv_seq
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_result,
  output logic            busy
);

  md_state_e state_q;
  md_state_e state_nx;

  md_op_e          op_q;
  logic [XLEN-1:0] b_q;
  logic [XLEN-1:0] acc_q;
  logic [XLEN-1:0] sh_q;
  logic [CNT_W-1:0] cnt_q;

  logic            accept;
  logic            div_zero;
  logic            is_div;
  logic            last_step;

  logic [XLEN:0]   t_shift;
  logic            q_bit;
  logic            add_en;
  logic            carry;
  logic [XLEN-1:0] hi_nx;

  logic [XLEN-1:0] alu_a;
  logic [3:0]      alu_ctrl;
  logic [XLEN-1:0] alu_y;
  logic            alu_zero_unused;
  logic [XLEN-1:0] res_mux;

  assign req_ready  = (state_q == MD_IDLE);
  assign busy       = (state_q != MD_IDLE);
  assign resp_valid = (state_q == MD_DONE);

  assign accept   = req_valid && req_ready;
  assign div_zero = req_op[1] && (req_b == '0);
  assign is_div   = md_is_div(op_q);
  assign last_step = (cnt_q == CNT_W'(XLEN - 1));

  // divide: shift the next dividend bit into the remainder
  assign t_shift = {acc_q, sh_q[XLEN-1]};
  assign q_bit   = (t_shift >= {1'b0, b_q});

  // multiply: add b into hi when the current multiplier bit is set
  assign add_en = sh_q[0];
  assign carry  = add_en && (alu_y < acc_q);
  assign hi_nx  = add_en ? alu_y : acc_q;

  always_comb begin
    alu_a    = acc_q;
    alu_ctrl = ALU_ADD;
    if (state_q == MD_RUN && is_div) begin
      alu_a    = t_shift[XLEN-1:0];
      alu_ctrl = ALU_SUB;
    end
  end

  alu #(
    .W(XLEN)
  ) u_alu (
    .a      (alu_a),
    .b      (b_q),
    .ctrl   (alu_ctrl),
    .result (alu_y),
    .zero   (alu_zero_unused)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
    end else begin
      state_q <= state_nx;
    end
  end

  always_comb begin
    state_nx = state_q;
    unique case (state_q)
      MD_IDLE: begin
        if (accept) begin
          state_nx = div_zero ? MD_DONE : MD_RUN;
        end
      end
      MD_RUN: begin
        if (last_step) begin
          state_nx = MD_DONE;
        end
      end
      MD_DONE: begin
        if (resp_ready) begin
          state_nx = MD_IDLE;
        end
      end
      default: state_nx = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q  <= MD_MUL;
      b_q   <= '0;
      acc_q <= '0;
      sh_q  <= '0;
      cnt_q <= '0;
    end else if (accept) begin
      op_q  <= md_op_e'(req_op);
      b_q   <= req_b;
      cnt_q <= '0;
      if (div_zero) begin
        // rem = a, quo = all ones
        acc_q <= req_a;
        sh_q  <= '1;
      end else begin
        acc_q <= '0;
        sh_q  <= req_a;
      end
    end else if (state_q == MD_RUN) begin
      cnt_q <= cnt_q + 1'b1;
      if (is_div) begin
        acc_q <= q_bit ? alu_y : t_shift[XLEN-1:0];
        sh_q  <= {sh_q[XLEN-2:0], q_bit};
      end else begin
        acc_q <= {carry, hi_nx[XLEN-1:1]};
        sh_q  <= {hi_nx[0], sh_q[XLEN-1:1]};
      end
    end
  end

  always_comb begin
    res_mux = '0;
    unique case (op_q)
      MD_MUL:   res_mux = sh_q;
      MD_MULHU: res_mux = acc_q;
      MD_DIVU:  res_mux = sh_q;
      MD_REMU:  res_mux = acc_q;
      default:  res_mux = '0;
    endcase
  end

  assign resp_result = resp_valid ? res_mux : '0;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq.
// Directed timing cases plus random ops against a plain-arithmetic model.
module tb_muldiv_seq;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_result;
  logic        busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit rnd_mode = 1'b0;
  logic [31:0] exp_q[$];

  muldiv_seq #(
    .XLEN(32),
    .CNT_W(5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] model(
    input logic [1:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    longint unsigned p;
    p = longint'(a) * longint'(b);
    case (op)
      2'b00: return p[31:0];
      2'b01: return p[63:32];
      2'b10: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic chk(
    input string       name,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // monitor: every consumed response is compared with the oldest expectation
  always @(negedge clk) begin
    if (rst_n && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL resp_unexpected got=%h exp=none", resp_result);
      end else begin
        chk("resp", resp_result, exp_q.pop_front());
      end
    end
  end

  task automatic issue(
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output int          t_acc
  );
    int n;
    n = 0;
    while (!req_ready && n < 300) begin
      @(posedge clk);
      #1;
      n++;
      if (rnd_mode) resp_ready = 1'($urandom_range(0, 1));
    end
    if (!req_ready) begin
      chk("req_ready_timeout", {31'b0, req_ready}, 32'd1);
      t_acc = cyc;
      return;
    end
    req_op = op;
    req_a = a;
    req_b = b;
    req_valid = 1'b1;
    exp_q.push_back(model(op, a, b));
    @(posedge clk);
    #1;
    t_acc = cyc;
    req_valid = 1'b0;
    req_a = $urandom;
    req_b = $urandom;
    req_op = 2'($urandom_range(0, 3));
  endtask

  // returns the cycle offset (accept edge T -> T+off) of the first resp_valid
  task automatic wait_resp(
    input  int   t_acc,
    output int   off,
    output logic busy_ok
  );
    busy_ok = 1'b1;
    off = -1;
    for (int k = 0; k < 60; k++) begin
      if (!busy) busy_ok = 1'b0;
      if (resp_valid) begin
        off = cyc - t_acc + 1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_op(
    input string       name,
    input logic [1:0]  op,
    input logic [31:0] a,
    input logic [31:0] b,
    input int          lat
  );
    int t, off;
    logic bok;
    issue(op, a, b, t);
    wait_resp(t, off, bok);
    chk({name, "_latency"}, off, lat);
    chk({name, "_busy"}, {31'b0, bok}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int t, tc, off;
    logic bok, stable;
    logic [31:0] v;
    logic [1:0]  op;
    logic [31:0] a, b;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_result", resp_result, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);

    resp_ready = 1'b1;
    run_op("mul_7x6", 2'b00, 32'd7, 32'd6, 33);
    chk("mul_idle_after", {31'b0, busy}, 32'd0);
    run_op("mulhu_ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    run_op("mul_ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 33);
    run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 33);
    run_op("divu_ff_1", 2'b10, 32'hFFFF_FFFF, 32'd1, 33);
    run_op("divu_5_0", 2'b10, 32'd5, 32'd0, 1);
    run_op("remu_5_0", 2'b11, 32'd5, 32'd0, 1);

    // backpressure
    resp_ready = 1'b0;
    issue(2'b10, 32'd1000, 32'd3, t);
    wait_resp(t, off, bok);
    chk("bp_latency", off, 33);
    v = resp_result;
    stable = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (!resp_valid || resp_result !== v || req_ready) stable = 1'b0;
    end
    chk("bp_stable", {31'b0, stable}, 32'd1);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    tc = cyc;
    chk("bp_idle_busy", {31'b0, busy}, 32'd0);
    chk("bp_idle_ready", {31'b0, req_ready}, 32'd1);
    issue(2'b00, 32'd9, 32'd11, t);
    chk("b2b_accept", t - tc, 32'd1);
    wait_resp(t, off, bok);
    chk("b2b_latency", off, 33);
    @(posedge clk);
    #1;

    // reset in the middle of a divide
    issue(2'b10, 32'd12345, 32'd67, t);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("midrst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_req_ready", {31'b0, req_ready}, 32'd1);
    run_op("post_rst_mul", 2'b00, 32'd3, 32'd5, 33);

    // random ops with random response backpressure
    rnd_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'd1;
        2: b = 32'($urandom_range(2, 255));
        3: b = a;
        default: b = $urandom;
      endcase
      issue(op, a, b, t);
    end
    rnd_mode = 1'b0;
    resp_ready = 1'b1;
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
